// File: rtl/change_fsm_pkg.sv
// change_fsm_pkg: shared definitions for the change controller.
//   - FSM state encoding (IDLE=0, VEND=1, PAYOUT=2)
//   - coin values (5, 10, 50) and the 8-bit credit width
//   - greedy_coin(): largest coin not exceeding a given amount
package change_fsm_pkg;

    localparam int unsigned CreditW = 8;

    typedef logic [CreditW-1:0] credit_t;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StVend   = 2'd1,
        StPayout = 2'd2
    } state_e;

    localparam credit_t Coin5  = 8'd5;
    localparam credit_t Coin10 = 8'd10;
    localparam credit_t Coin50 = 8'd50;

    // Largest coin <= amt, or 0 when amt is below the smallest coin.
    function automatic credit_t greedy_coin(input credit_t amt);
        if (amt >= Coin50) begin
            return Coin50;
        end else if (amt >= Coin10) begin
            return Coin10;
        end else if (amt >= Coin5) begin
            return Coin5;
        end else begin
            return '0;
        end
    endfunction

endpackage

// File: rtl/coin_payout.sv
// coin_payout: gap counter and greedy coin selection for paying out change.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start_i           clears the gap counter when a payout is launched
//   active_i          controller is in VEND or PAYOUT
//   amount_i          remaining change (owned by the controller)
//   ret5_o/10_o/50_o  registered one-cycle coin-return pulses
//   take_o            value paid this cycle; controller subtracts it
//   done_o            gap expired and nothing left to pay
module coin_payout
    import change_fsm_pkg::*;
#(
    parameter int unsigned GAP = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    start_i,
    input  logic    active_i,
    input  credit_t amount_i,
    output logic    ret5_o,
    output logic    ret10_o,
    output logic    ret50_o,
    output credit_t take_o,
    output logic    done_o
);

    localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GapW-1:0] GapReload = GapW'(GAP - 1);

    logic [GapW-1:0] gap_q, gap_d;
    logic            ret5_q, ret10_q, ret50_q;
    logic            fire;

    always_comb begin
        fire   = active_i && (gap_q == '0) && (amount_i != '0);
        take_o = fire ? greedy_coin(amount_i) : '0;
        done_o = (gap_q == '0) && (amount_i == '0);

        gap_d = gap_q;
        if (start_i) begin
            gap_d = '0;
        end else if (fire) begin
            gap_d = GapReload;
        end else if (active_i && gap_q != '0) begin
            gap_d = gap_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_q   <= '0;
            ret5_q  <= 1'b0;
            ret10_q <= 1'b0;
            ret50_q <= 1'b0;
        end else begin
            gap_q   <= gap_d;
            ret5_q  <= (take_o == Coin5);
            ret10_q <= (take_o == Coin10);
            ret50_q <= (take_o == Coin50);
        end
    end

    assign ret5_o  = ret5_q;
    assign ret10_o = ret10_q;
    assign ret50_o = ret50_q;

endmodule

// File: rtl/change_fsm.sv
// change_fsm: vending/change controller driven by one-pulse button inputs.
// Accumulates coin credit, vends when credit covers PRICE, and pays out the
// change (or cancelled credit) as spaced greedy coin-return pulses.
// Ports:
//   clk, rst                clock, asynchronous active-high reset
//   coin5/coin10/coin50     one-cycle coin-insert pulses
//   buy, cancel             one-cycle purchase / refund requests
//   credit                  current credit, remaining change during payout
//   dispense, deny, reject  one-cycle status pulses
//   ret5/ret10/ret50        one-cycle coin-return pulses
//   busy                    high while not idle
// All outputs are registered.
module change_fsm
    import change_fsm_pkg::*;
#(
    parameter int unsigned PRICE      = 35,
    parameter int unsigned MAX_CREDIT = 200,
    parameter int unsigned GAP        = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    coin5,
    input  logic    coin10,
    input  logic    coin50,
    input  logic    buy,
    input  logic    cancel,
    output credit_t credit,
    output logic    dispense,
    output logic    deny,
    output logic    reject,
    output logic    ret5,
    output logic    ret10,
    output logic    ret50,
    output logic    busy
);

    localparam credit_t    PriceC   = CreditW'(PRICE);
    localparam logic [8:0] MaxCred9 = 9'(MAX_CREDIT);

    state_e  state_q, state_d;
    credit_t credit_q, credit_d;
    logic    dispense_q, dispense_d;
    logic    deny_q, deny_d;
    logic    reject_q, reject_d;
    logic    busy_q;

    logic       any_coin, multi_coin, start, coin_fits;
    credit_t    coin_val, take;
    logic [8:0] coin_sum;
    logic       pay_done;

    coin_payout #(
        .GAP (GAP)
    ) u_payout (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start),
        .active_i (state_q != StIdle),
        .amount_i (credit_q),
        .ret5_o   (ret5),
        .ret10_o  (ret10),
        .ret50_o  (ret50),
        .take_o   (take),
        .done_o   (pay_done)
    );

    always_comb begin
        any_coin   = coin5 | coin10 | coin50;
        multi_coin = (coin5 & coin10) | (coin5 & coin50) | (coin10 & coin50);
        // Only the highest-valued coin of a simultaneous group is considered.
        coin_val   = coin50 ? Coin50 : coin10 ? Coin10 : coin5 ? Coin5 : '0;
        coin_sum   = {1'b0, credit_q} + {1'b0, coin_val};
        coin_fits  = coin_sum <= MaxCred9;

        state_d    = state_q;
        credit_d   = credit_q;
        dispense_d = 1'b0;
        deny_d     = 1'b0;
        reject_d   = 1'b0;
        start      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cancel) begin
                    reject_d = any_coin;
                    if (credit_q != '0) begin
                        state_d = StPayout;
                        start   = 1'b1;
                    end
                end else if (buy) begin
                    reject_d = any_coin;
                    if (credit_q >= PriceC) begin
                        state_d    = StVend;
                        dispense_d = 1'b1;
                        credit_d   = credit_q - PriceC;
                    end else begin
                        deny_d = 1'b1;
                    end
                end else if (any_coin) begin
                    if (coin_fits) begin
                        credit_d = coin_sum[7:0];
                    end
                    reject_d = multi_coin || !coin_fits;
                end
            end
            StVend: begin
                // Gap counter is 0 here, so the first change coin goes out
                // on the edge that leaves VEND.
                reject_d = any_coin;
                credit_d = credit_q - take;
                state_d  = (credit_q != '0) ? StPayout : StIdle;
            end
            StPayout: begin
                reject_d = any_coin;
                credit_d = credit_q - take;
                if (pay_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            credit_q   <= '0;
            dispense_q <= 1'b0;
            deny_q     <= 1'b0;
            reject_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            dispense_q <= dispense_d;
            deny_q     <= deny_d;
            reject_q   <= reject_d;
            busy_q     <= (state_d != StIdle);
        end
    end

    assign credit   = credit_q;
    assign dispense = dispense_q;
    assign deny     = deny_q;
    assign reject   = reject_q;
    assign busy     = busy_q;

endmodule
